// File: rtl/mac_array_os_if.sv
// mac_array_os_if: job control, operand beat and result row streams of mac_array_os
// master (fetch/writeback side) drives start/k_len/data_type, in_valid/a_vec/b_vec, out_ready
// slave (the array) drives in_ready, out_valid/out_row/out_row_idx/out_last, busy, sat_flag
interface mac_array_os_if #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int K_WIDTH    = 16,
    parameter int IDX_W      = (ROWS > 1) ? $clog2(ROWS) : 1
);
    logic                       start;
    logic [K_WIDTH-1:0]         k_len;
    logic                       data_type;
    logic                       in_valid;
    logic                       in_ready;
    logic [ROWS*DATA_WIDTH-1:0] a_vec;
    logic [COLS*DATA_WIDTH-1:0] b_vec;
    logic                       out_valid;
    logic                       out_ready;
    logic [COLS*ACC_WIDTH-1:0]  out_row;
    logic [IDX_W-1:0]           out_row_idx;
    logic                       out_last;
    logic                       busy;
    logic                       sat_flag;
    modport master (
        output start, k_len, data_type, in_valid, a_vec, b_vec, out_ready,
        input  in_ready, out_valid, out_row, out_row_idx, out_last, busy, sat_flag
    );
    modport slave (
        input  start, k_len, data_type, in_valid, a_vec, b_vec, out_ready,
        output in_ready, out_valid, out_row, out_row_idx, out_last, busy, sat_flag
    );
endinterface

// File: rtl/mac_array_os.sv
// mac_array_os: output-stationary ROWS x COLS outer-product MAC array with row-wise drain
// ports: clk, rst_n (async active-low), io (mac_array_os_if.slave: job start, operand beats, result rows)
// MAC_ARRAY_SAT_EN: when defined, accumulators saturate and raise sticky sat_flag; otherwise they wrap
module mac_array_os #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int K_WIDTH    = 16,
    parameter int IDX_W      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input logic          clk,
    input logic          rst_n,
    mac_array_os_if.slave io
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
    state_t state, state_nxt;
    logic [K_WIDTH-1:0] k_reg, cnt;
    logic dt;
    logic [IDX_W-1:0] row;
    logic [ROWS-1:0][COLS-1:0][ACC_WIDTH-1:0] acc, acc_nxt;
    logic signed [DATA_WIDTH-1:0] a_d [ROWS];
    logic signed [DATA_WIDTH-1:0] b_d [COLS];
    logic go, fire_in, fire_out, last_row;
    assign go       = state == IDLE && io.start;
    assign fire_in  = state == ACCUM && io.in_valid;
    assign fire_out = state == DRAIN && io.out_ready;
    assign last_row = row == IDX_W'(ROWS - 1);
    // int8 mode keeps only the low byte of each lane, sign-extended
    function automatic logic signed [DATA_WIDTH-1:0] decode(input logic [DATA_WIDTH-1:0] lane, input logic wide);
        return wide ? $signed(lane) : DATA_WIDTH'($signed(lane[7:0]));
    endfunction
    for (genvar i = 0; i < ROWS; i++) begin : g_a
        assign a_d[i] = decode(io.a_vec[i*DATA_WIDTH +: DATA_WIDTH], dt);
    end
    for (genvar j = 0; j < COLS; j++) begin : g_b
        assign b_d[j] = decode(io.b_vec[j*DATA_WIDTH +: DATA_WIDTH], dt);
    end
`ifdef MAC_ARRAY_SAT_EN
    logic [ROWS*COLS-1:0] clamp;
    logic sat;
`endif
    for (genvar i = 0; i < ROWS; i++) begin : g_r
        for (genvar j = 0; j < COLS; j++) begin : g_c
            logic signed [2*DATA_WIDTH-1:0] prod;
            assign prod = (2*DATA_WIDTH)'(a_d[i]) * (2*DATA_WIDTH)'(b_d[j]);
`ifdef MAC_ARRAY_SAT_EN
            // one guard bit: overflow iff the two top bits of the wide sum disagree
            logic signed [ACC_WIDTH:0] sum;
            assign sum = (ACC_WIDTH+1)'($signed(acc[i][j])) + (ACC_WIDTH+1)'(prod);
            assign clamp[i*COLS+j] = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
            assign acc_nxt[i][j] = clamp[i*COLS+j] ? {sum[ACC_WIDTH], {(ACC_WIDTH-1){~sum[ACC_WIDTH]}}}
                                                   : sum[ACC_WIDTH-1:0];
`else
            assign acc_nxt[i][j] = acc[i][j] + ACC_WIDTH'(prod);
`endif
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (io.start) state_nxt = io.k_len != '0 ? ACCUM : DRAIN;
            ACCUM:   if (io.in_valid && cnt == k_reg - K_WIDTH'(1)) state_nxt = DRAIN;
            DRAIN:   if (io.out_ready && last_row) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            k_reg <= '0;
            cnt   <= '0;
            dt    <= 1'b0;
            row   <= '0;
            acc   <= '0;
        end else begin
            if (go) begin
                k_reg <= io.k_len;
                dt    <= io.data_type;
                cnt   <= '0;
                row   <= '0;
                acc   <= '0;
            end
            if (fire_in) begin
                cnt <= cnt + K_WIDTH'(1);
                acc <= acc_nxt;
            end
            if (fire_out) row <= last_row ? '0 : row + IDX_W'(1);
        end
`ifdef MAC_ARRAY_SAT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sat <= 1'b0;
        else if (go) sat <= 1'b0;
        else if (fire_in && |clamp) sat <= 1'b1;
    assign io.sat_flag = sat;
`else
    assign io.sat_flag = 1'b0;
`endif
    assign io.in_ready    = state == ACCUM;
    assign io.out_valid   = state == DRAIN;
    assign io.busy        = state != IDLE;
    assign io.out_last    = state == DRAIN && last_row;
    assign io.out_row_idx = row;
    assign io.out_row     = acc[row];
endmodule

// File: tb/tb_mac_array_os.sv
// tb_mac_array_os: directed and random jobs checked against an arithmetic outer-product model
module tb_mac_array_os;
    localparam int R = 4, C = 4;
    localparam longint AMAX = 64'sh7FFFFFFF;
    localparam longint AMIN = -64'sh80000000;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    mac_array_os_if bus ();
    mac_array_os dut (.clk(clk), .rst_n(rst_n), .io(bus));
    int checks = 0, errors = 0;
    longint macc [R][C];
    bit msat;
    logic [15:0] a_mem [64][R];
    logic [15:0] b_mem [64][C];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint dec(input logic [15:0] v, input bit dt);
        logic [7:0] lo;
        lo = v[7:0];
        return dt ? longint'($signed(v)) : longint'($signed(lo));
    endfunction

    task automatic model_beat(input int b, input bit dt);
        longint s;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                s = macc[i][j] + dec(a_mem[b][i], dt) * dec(b_mem[b][j], dt);
`ifdef MAC_ARRAY_SAT_EN
                if (s > AMAX) begin s = AMAX; msat = 1; end
                else if (s < AMIN) begin s = AMIN; msat = 1; end
`else
                s = longint'($signed(s[31:0]));
`endif
                macc[i][j] = s;
            end
    endtask

    task automatic drive_beat(input int b);
        for (int i = 0; i < R; i++) bus.a_vec[i*16 +: 16] = a_mem[b][i];
        for (int j = 0; j < C; j++) bus.b_vec[j*16 +: 16] = b_mem[b][j];
    endtask

    task automatic fill_random(input int k);
        for (int b = 0; b < k; b++) begin
            for (int i = 0; i < R; i++) a_mem[b][i] = 16'($urandom);
            for (int j = 0; j < C; j++) b_mem[b][j] = 16'($urandom);
        end
    endtask

    task automatic fill_const(input int k, input logic [15:0] av, input logic [15:0] bv);
        for (int b = 0; b < k; b++) begin
            for (int i = 0; i < R; i++) a_mem[b][i] = av;
            for (int j = 0; j < C; j++) b_mem[b][j] = bv;
        end
    endtask

    // one full job: start, k beats (optionally with idle gaps), drain with optional 5-cycle stall on one row
    task automatic run_job(input string name, input int k, input bit dt, input bit gap, input int stall);
        logic [127:0] e;
        check({name, " idle before start"}, 128'(bus.busy), 128'(0));
        bus.start = 1; bus.k_len = k[15:0]; bus.data_type = dt;
        for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) macc[i][j] = 0;
        msat = 0;
        @(posedge clk); #1;
        bus.start = 0;
        check({name, " busy after start"}, 128'(bus.busy), 128'(1));
        check({name, " in_ready after start"}, 128'(bus.in_ready), 128'(k != 0));
        check({name, " out_valid after start"}, 128'(bus.out_valid), 128'(k == 0));
        for (int b = 0; b < k; b++) begin
            if (gap && b > 0) begin
                bus.in_valid = 0;
                drive_beat(0);
                @(posedge clk); #1;
                check({name, " gap out_valid"}, 128'(bus.out_valid), 128'(0));
            end
            bus.in_valid = 1;
            drive_beat(b);
            check({name, " in_ready"}, 128'(bus.in_ready), 128'(1));
            @(posedge clk); #1;
            model_beat(b, dt);
            check({name, " sat_flag"}, 128'(bus.sat_flag), 128'(msat));
        end
        bus.in_valid = 0;
        for (int r = 0; r < R; r++) begin
            e = '0;
            for (int j = 0; j < C; j++) e[j*32 +: 32] = macc[r][j][31:0];
            if (r == stall) begin
                bus.out_ready = 0;
                repeat (5) begin
                    check({name, " stall out_valid"}, 128'(bus.out_valid), 128'(1));
                    check({name, " stall idx"}, 128'(bus.out_row_idx), 128'(r));
                    check({name, " stall row"}, bus.out_row, e);
                    @(posedge clk); #1;
                end
            end
            bus.out_ready = 1;
            check({name, " out_valid"}, 128'(bus.out_valid), 128'(1));
            check({name, " idx"}, 128'(bus.out_row_idx), 128'(r));
            check({name, " last"}, 128'(bus.out_last), 128'(r == R - 1));
            check({name, " row"}, bus.out_row, e);
            @(posedge clk); #1;
        end
        bus.out_ready = 0;
        check({name, " busy after drain"}, 128'(bus.busy), 128'(0));
        check({name, " out_valid after drain"}, 128'(bus.out_valid), 128'(0));
        check({name, " sat_flag held"}, 128'(bus.sat_flag), 128'(msat));
    endtask

    task automatic check_reset(input string name);
        check({name, " in_ready"}, 128'(bus.in_ready), 128'(0));
        check({name, " out_valid"}, 128'(bus.out_valid), 128'(0));
        check({name, " out_last"}, 128'(bus.out_last), 128'(0));
        check({name, " busy"}, 128'(bus.busy), 128'(0));
        check({name, " sat_flag"}, 128'(bus.sat_flag), 128'(0));
        check({name, " out_row"}, bus.out_row, 128'(0));
        check({name, " out_row_idx"}, 128'(bus.out_row_idx), 128'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 0; bus.k_len = '0; bus.data_type = 0; bus.in_valid = 0;
        bus.a_vec = '0; bus.b_vec = '0; bus.out_ready = 0;
        #12;
        check_reset("reset");
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        a_mem[0] = '{16'd1, 16'd2, 16'd3, 16'd4};
        b_mem[0] = '{16'd5, 16'd6, 16'd7, 16'd8};
        run_job("basic", 1, 1, 0, -1);
        fill_const(3, 16'hAAFF, 16'h0002);
        run_job("int8", 3, 0, 0, -1);
        fill_const(3, 16'h8000, 16'h8000);
        run_job("overflow", 3, 1, 0, -1);
        fill_random(4);
        run_job("gapped", 4, 1, 1, 1);
        run_job("continuous", 4, 1, 0, -1);
        run_job("zero", 0, 1, 0, -1);
        fill_random(5);
        bus.start = 1; bus.k_len = 16'd5; bus.data_type = 1;
        @(posedge clk); #1;
        bus.start = 0;
        for (int b = 0; b < 2; b++) begin
            bus.in_valid = 1;
            drive_beat(b);
            @(posedge clk); #1;
        end
        rst_n = 0;
        #1;
        check_reset("mid-job reset");
        @(posedge clk); #1;
        rst_n = 1;
        bus.in_valid = 0;
        @(posedge clk); #1;
        check_reset("after reset release");
        fill_random(1);
        run_job("post-reset", 1, 1, 0, -1);
        for (int n = 0; n < 12; n++) begin
            int k;
            k = $urandom_range(1, 8);
            fill_random(k);
            run_job("random", k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 4));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_array_os.md
# mac_array_os

Parametrised output-stationary MAC array: the successor to the fixed 8x8 array. Runs a job of `k_len` operand beats. Each accepted beat multiplies an A column vector (ROWS lanes) by a B row vector (COLS lanes) as an outer product and adds the result into ROWS x COLS accumulators. After the last beat it drains the accumulators one row per cycle over a valid/ready stream. It sits between the operand fetch/buffer stage and the writeback/requantisation stage of the accelerator datapath.

## Interface
- `ROWS`, 4: accumulator rows; number of A lanes.
- `COLS`, 4: accumulator columns; number of B lanes.
- `DATA_WIDTH`, 16: operand lane width. Must be at least 8.
- `ACC_WIDTH`, 32: accumulator width. Must be at least 2*DATA_WIDTH.
- `K_WIDTH`, 16: width of `k_len` and of the beat counter.
- `IDX_W`, max(1, $clog2(ROWS)): width of `out_row_idx`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: job request; sampled only in IDLE.
- `k_len` in K_WIDTH: beats in the job; latched on start.
- `data_type` in 1: 0 = int8, 1 = int16; latched on start.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: array accepts a beat.
- `a_vec` in ROWS*DATA_WIDTH: lane i is bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `b_vec` in COLS*DATA_WIDTH: lane j is packed the same way.
- `out_valid` out 1: result row valid.
- `out_ready` in 1: downstream accepts the row.
- `out_row` out COLS*ACC_WIDTH: lane j holds `acc[out_row_idx][j]`.
- `out_row_idx` out IDX_W: index of the row presented.
- `out_last` out 1: asserted with row ROWS-1.
- `busy` out 1: state is not IDLE.
- `sat_flag` out 1: sticky; set if any accumulator saturated during the current job.

## Operation
- States: IDLE, ACCUM, DRAIN.
- IDLE:
  - `start` clears every accumulator, clears `sat_flag`, clears the beat counter and latches `k_len` and `data_type`.
  - Next state is ACCUM if `k_len` != 0, otherwise DRAIN.
- ACCUM:
  - `in_ready` = 1.
  - Each `in_valid && in_ready` beat updates every accumulator: `acc[i][j] += a_i * b_j`, and increments the beat counter.
  - On the beat where counter == `k_len`-1, next state is DRAIN.
  - Cycles without `in_valid` do nothing.
- DRAIN:
  - `out_valid` = 1 and rows are presented starting from row 0.
  - Each `out_valid && out_ready` advances the row index.
  - The handshake on row ROWS-1 returns the block to IDLE.
  - `out_row`, `out_row_idx` and `out_last` hold stable while `out_valid && !out_ready`.
- Operand decode:
  - int8: the low 8 bits of each lane are sign-extended to DATA_WIDTH; upper bits are ignored.
  - int16: the full lane is signed.
- Product is signed, 2*DATA_WIDTH bits, sign-extended to ACC_WIDTH. The sum is formed at ACC_WIDTH+1 bits.
- Overflow handling follows `MAC_ARRAY_SAT_EN` (see Configuration).
- `start` outside IDLE is ignored.
- `in_valid` outside ACCUM is ignored (`in_ready` = 0).
- Reset mid-job abandons the job. All state, accumulators and outputs return to reset values.
- Reset values: `in_ready`, `out_valid`, `out_last`, `busy`, `sat_flag` = 0; `out_row` = 0; `out_row_idx` = 0; all accumulators 0; state IDLE.

## Timing
- `start` sampled at edge N: `busy` and `in_ready` are high in cycle N+1.
  - If `k_len` = 0, `out_valid` is high in cycle N+1 instead, and all rows drain as zero.
- Accumulators are updated at the same edge as the beat handshake.
- Last beat accepted at edge M: `out_valid` is high with row 0 in cycle M+1.
- Throughput: one beat per cycle; one row per cycle when `out_ready` is held high.
- Last row accepted at edge D: IDLE in cycle D+1 with `busy` = 0. A `start` in that cycle is accepted, giving a one-cycle gap between jobs.
- `sat_flag` is valid from the cycle after the saturating beat and holds until the next `start`.

## Configuration
- `MAC_ARRAY_SAT_EN` defined:
  - A sum above the ACC_WIDTH signed max clamps to `{0,1...1}`.
  - A sum below the ACC_WIDTH signed min clamps to `{1,0...0}`.
  - Any clamp sets `sat_flag`.
- Undefined:
  - Sums wrap modulo 2^ACC_WIDTH.
  - `sat_flag` is tied to 0.
  - No clamp logic is instantiated.

## Test plan
- Basic outer product: ROWS=COLS=4, int16, `k_len`=1, a=[1,2,3,4], b=[5,6,7,8] -> row i = (i+1)*[5,6,7,8]; rows 0..3 in order; `out_last` only with row 3.
- int8 decode: a lanes 16'hAAFF, b lanes 16'h0002, `k_len`=3 -> every accumulator = -6 (32'hFFFFFFFA).
- Overflow: int16, a=b=16'h8000, `k_len`=3, giving a true sum of 3*2^30.
  - With `MAC_ARRAY_SAT_EN`: 32'h7FFFFFFF and `sat_flag`=1.
  - Without: 32'hC0000000 and `sat_flag`=0.
- Backpressure and gaps:
  - `in_valid` toggled every other cycle over `k_len`=4 gives the same results as continuous input.
  - `out_ready` held low for 5 cycles on row 1: `out_row` and `out_row_idx`=1 stay stable; no row is skipped or repeated.
- Zero-length job: `k_len`=0 -> `out_valid` in the cycle after `start`; all four rows are zero; back in IDLE after four handshakes.
- Reset mid-job: `rst_n` low after 2 of 5 beats -> all outputs 0 and `busy`=0; a subsequent `k_len`=1 job returns only the new products.
